pipe_ctrl_hazard_unit: RTL and testbench
========================================

// Module: pipe_ctrl_hazard_unit
// PURPOSE
//  ID-stage control for the 5-stage MIPS pipeline.
//  - Decodes opcode/func.
//  - Resolves BEQ/BNE/J in ID.
//  - Detects load-use and branch-operand hazards.
//  - Owns the ID/EX control register, driving the EX-stage control bundle.
//  - Supersedes the combinational CU: registered outputs, stall/flush generation, parametrised widths.
// PARAMETERS
//  REG_ADDR_W  5  register-file address width
//  FUNC_W      6  R-type func field width
//  MUL_LAT     4  MULT occupancy in cycles (>=2; used only with MULDIV_EN)
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous, active-high reset
//  id_valid      in   1           IF/ID holds a real instruction
//  opcode        in   6           instr[31:26]
//  func_in       in   FUNC_W      instr[5:0]
//  id_rs         in   REG_ADDR_W  source reg rs
//  id_rt         in   REG_ADDR_W  source reg rt
//  id_rd         in   REG_ADDR_W  dest reg rd
//  eq_regs       in   1           ID register-compare result (rs==rt)
//  pc_src        out  2           00 PC+4, 01 branch target, 10 jump target (combinational)
//  pc_write      out  1           0 holds PC (combinational)
//  ifid_write    out  1           0 holds IF/ID (combinational)
//  ifid_flush    out  1           1 zeroes IF/ID next edge (combinational)
//  stall         out  1           hazard stall this cycle (combinational)
//  illegal_op    out  1           1-cycle pulse, unknown opcode/func decoded
//  ex_valid      out  1           ID/EX holds a real instruction
//  ex_mem_read   out  1           registered EX controls ...
//  ex_mem_write  out  1
//  ex_alu_src    out  1
//  ex_reg_write  out  1
//  ex_mem_to_reg out  1
//  ex_func       out  FUNC_W      ALU func (ADD=100000 for LW/SW, NOP=000000 otherwise)
//  ex_dst        out  REG_ADDR_W  write-back reg: rd for R-type, rt for LW, 0 otherwise
// BEHAVIOUR
//  Reset (async, rst=1): ID/EX = bubble; MULT counter = 0.
//   Bubble = all ex_* 0, ex_func=NOP, ex_dst=0, ex_valid=0.
//   While rst=1, combinational outputs are pc_src=00, pc_write=1, ifid_write=1, flush=0, stall=0, illegal_op=0.
//  Decode:
//   LW  -> alu_src, mem_read, reg_write, mem_to_reg, func=ADD, dst=rt
//   SW  -> alu_src, mem_write, func=ADD
//   RTYPE -> reg_write, func=func_in, dst=rd
//   BEQ/BNE/J -> no EX controls
//   Unknown -> bubble + illegal_op
//  Load-use hazard (stall=1):
//   Condition: ex_valid & ex_mem_read & ex_dst!=0 & (ex_dst==id_rs | (ex_dst==id_rt & op in {RTYPE,SW,BEQ,BNE})).
//  Branch hazard (stall=1):
//   Condition: op in {BEQ,BNE} & ex_valid & ex_reg_write & ex_dst!=0 & ex_dst in {id_rs,id_rt}.
//  Stall:
//   pc_write=0, ifid_write=0, ID/EX loads bubble, pc_src=00, ifid_flush=0.
//   The stalled instruction re-decodes next cycle.
//  Branch/jump (no stall):
//   BEQ&eq_regs or BNE&!eq_regs -> pc_src=01, ifid_flush=1.
//   J -> pc_src=10, ifid_flush=1.
//   Not taken -> 00.
//  id_valid=0: treated as bubble; no hazard, no redirect, no illegal_op.
//  Priority: rst > stall > redirect > normal advance.
//  Latency: control appears on ex_* exactly 1 clk after decode.
// CONFIGURATION
//  MULDIV_EN defined:
//   RTYPE func 011000 (MULT) is legal: dst=0, reg_write=0, func=MULT.
//   On its ID/EX load, counter = MUL_LAT-1; while counter!=0, stall=1 and counter decrements each clk.
//   MULT in ID while counter!=0 also stalls.
//  MULDIV_EN undefined: MULT is illegal (bubble + illegal_op); no counter logic.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode/func localparams (LW, SW, BEQ, BNE, J, RTYPE, ADDF, NOPF, MULTF); ctrl_t struct for the EX bundle.
//  Sub-module hazard_detect: combinational load-use, branch, and MULT-busy stall terms.
// TESTING
//  1. LW r2 then ADD rd=r3,rs=r2 -> stall=1 for 1 cycle, pc_write=0; next edge ex_valid=0, then ADD with ex_dst=3.
//  2. ADD writes r4, then BEQ r4,r5 with eq_regs=1 -> 1 stall, then pc_src=01, ifid_flush=1.
//  3. BNE, eq_regs=1 -> pc_src=00, no flush. J -> pc_src=10, ifid_flush=1.
//  4. LW with ex_dst=0 before ADD rs=r0 -> no stall.
//  5. opcode 111111 -> illegal_op pulse, bubble in ID/EX.
//  6. MULDIV_EN, MUL_LAT=4: MULT -> stall 3 cycles. Assert rst mid-count -> counter 0, bubble, stall=0.

Source files
------------

// File: rtl/pipe_ctrl_hazard_unit_pkg.sv
// Shared opcode/func encodings and the EX-stage control bundle type for the
// ID-stage control and hazard unit.
package mips_ctrl_pkg;

   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] J     = 6'b000010;
   localparam logic [5:0] BEQ   = 6'b000100;
   localparam logic [5:0] BNE   = 6'b000101;
   localparam logic [5:0] LW    = 6'b100011;
   localparam logic [5:0] SW    = 6'b101011;

   localparam logic [5:0] NOPF  = 6'b000000;
   localparam logic [5:0] MULTF = 6'b011000;
   localparam logic [5:0] ADDF  = 6'b100000;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_e;

   typedef struct packed {
      logic valid;
      logic mem_read;
      logic mem_write;
      logic alu_src;
      logic reg_write;
      logic mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_hazard_unit_if.sv
// Bundle between the IF/ID stage, the PC logic and the ID/EX control register.
interface pipe_ctrl_hazard_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int FUNC_W     = 6
);
   logic                  id_valid;
   logic [5:0]            opcode;
   logic [FUNC_W-1:0]     func_in;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  eq_regs;

   logic [1:0]            pc_src;
   logic                  pc_write;
   logic                  ifid_write;
   logic                  ifid_flush;
   logic                  stall;
   logic                  illegal_op;
   logic                  ex_valid;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  ex_alu_src;
   logic                  ex_reg_write;
   logic                  ex_mem_to_reg;
   logic [FUNC_W-1:0]     ex_func;
   logic [REG_ADDR_W-1:0] ex_dst;

   modport master (
      output id_valid, opcode, func_in, id_rs, id_rt, id_rd, eq_regs,
      input  pc_src, pc_write, ifid_write, ifid_flush, stall, illegal_op,
      input  ex_valid, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write,
      input  ex_mem_to_reg, ex_func, ex_dst
   );

   modport slave (
      input  id_valid, opcode, func_in, id_rs, id_rt, id_rd, eq_regs,
      output pc_src, pc_write, ifid_write, ifid_flush, stall, illegal_op,
      output ex_valid, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write,
      output ex_mem_to_reg, ex_func, ex_dst
   );

endinterface

// File: rtl/pipe_ctrl_hazard_unit_hazard_detect.sv
// Combinational stall terms: load-use, branch-operand and multiplier-busy.
module hazard_detect
   import mips_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_valid_i,
   input  logic [5:0]            op_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_reg_write_i,
   input  logic [REG_ADDR_W-1:0] ex_dst_i,
   input  logic                  mul_busy_i,
   output logic                  load_use_o,
   output logic                  branch_haz_o,
   output logic                  mul_stall_o,
   output logic                  stall_o
);

   logic is_branch;
   logic uses_rt;
   logic dst_live;
   logic hit_rs;
   logic hit_rt;

   assign is_branch = (op_i == BEQ) || (op_i == BNE);
   // Only these formats actually read rt as a source; LW/J do not.
   assign uses_rt   = (op_i == RTYPE) || (op_i == SW) || is_branch;
   assign dst_live  = ex_valid_i && (ex_dst_i != '0);
   assign hit_rs    = (ex_dst_i == id_rs_i);
   assign hit_rt    = (ex_dst_i == id_rt_i);

   assign load_use_o   = id_valid_i && dst_live && ex_mem_read_i &&
                         (hit_rs || (hit_rt && uses_rt));
   assign branch_haz_o = id_valid_i && dst_live && is_branch && ex_reg_write_i &&
                         (hit_rs || hit_rt);
   assign mul_stall_o  = mul_busy_i;
   assign stall_o      = load_use_o || branch_haz_o || mul_stall_o;

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// ID-stage decode, branch/jump resolution, hazard stalls and the ID/EX control
// register. Define MULDIV_EN to accept MULT with a MUL_LAT-cycle busy counter.
module pipe_ctrl_hazard_unit
   import mips_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int FUNC_W     = 6,
   parameter int MUL_LAT    = 4
) (
   input logic                     clk,
   input logic                     rst,
   pipe_ctrl_hazard_unit_if.slave  bus
);

   if (MUL_LAT < 2) begin : g_bad_mul_lat
      $error("MUL_LAT must be at least 2");
   end

   ctrl_t                 dec_ctrl;
   logic [FUNC_W-1:0]     dec_func;
   logic [REG_ADDR_W-1:0] dec_dst;
   logic                  dec_illegal;
   logic                  dec_is_mult;

   ctrl_t                 ex_ctrl_q, ex_ctrl_d;
   logic [FUNC_W-1:0]     ex_func_q, ex_func_d;
   logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;

   logic mul_busy;
   logic hz_stall;
   logic load_use;
   logic branch_haz;
   logic mul_stall;
   logic stall;
   logic advance;
   logic taken;
   logic jump;
   logic load_id_ex;

   always_comb begin
      dec_ctrl    = CTRL_BUBBLE;
      dec_func    = FUNC_W'(NOPF);
      dec_dst     = '0;
      dec_illegal = 1'b0;
      dec_is_mult = 1'b0;
      case (bus.opcode)
         LW: begin
            dec_ctrl.valid      = 1'b1;
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_func            = FUNC_W'(ADDF);
            dec_dst             = bus.id_rt;
         end
         SW: begin
            dec_ctrl.valid     = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.mem_write = 1'b1;
            dec_func           = FUNC_W'(ADDF);
         end
         RTYPE: begin
            if (bus.func_in == FUNC_W'(MULTF)) begin
`ifdef MULDIV_EN
               dec_ctrl.valid = 1'b1;
               dec_func       = bus.func_in;
               dec_is_mult    = 1'b1;
`else
               dec_illegal    = 1'b1;
`endif
            end else begin
               dec_ctrl.valid     = 1'b1;
               dec_ctrl.reg_write = 1'b1;
               dec_func           = bus.func_in;
               dec_dst            = bus.id_rd;
            end
         end
         BEQ, BNE, J: begin
            dec_ctrl.valid = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .id_valid_i     (bus.id_valid),
      .op_i           (bus.opcode),
      .id_rs_i        (bus.id_rs),
      .id_rt_i        (bus.id_rt),
      .ex_valid_i     (ex_ctrl_q.valid),
      .ex_mem_read_i  (ex_ctrl_q.mem_read),
      .ex_reg_write_i (ex_ctrl_q.reg_write),
      .ex_dst_i       (ex_dst_q),
      .mul_busy_i     (mul_busy),
      .load_use_o     (load_use),
      .branch_haz_o   (branch_haz),
      .mul_stall_o    (mul_stall),
      .stall_o        (hz_stall)
   );

   // Reset dominates every combinational output; stall dominates redirects.
   assign stall      = !rst && hz_stall;
   assign advance    = !rst && bus.id_valid && !stall;
   assign taken      = advance && (((bus.opcode == BEQ) && bus.eq_regs) ||
                                   ((bus.opcode == BNE) && !bus.eq_regs));
   assign jump       = advance && (bus.opcode == J);
   assign load_id_ex = advance && !dec_illegal;

   always_comb begin
      bus.pc_src = PC_SEQ;
      if (jump) begin
         bus.pc_src = PC_JUMP;
      end else if (taken) begin
         bus.pc_src = PC_BRANCH;
      end
   end

   assign bus.pc_write   = !stall;
   assign bus.ifid_write = !stall;
   assign bus.ifid_flush = taken || jump;
   assign bus.stall      = stall;
   assign bus.illegal_op = advance && dec_illegal;

   always_comb begin
      ex_ctrl_d = CTRL_BUBBLE;
      ex_func_d = FUNC_W'(NOPF);
      ex_dst_d  = '0;
      if (load_id_ex) begin
         ex_ctrl_d = dec_ctrl;
         ex_func_d = dec_func;
         ex_dst_d  = dec_dst;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_ctrl_q <= CTRL_BUBBLE;
         ex_func_q <= FUNC_W'(NOPF);
         ex_dst_q  <= '0;
      end else begin
         ex_ctrl_q <= ex_ctrl_d;
         ex_func_q <= ex_func_d;
         ex_dst_q  <= ex_dst_d;
      end
   end

`ifdef MULDIV_EN
   localparam int CNT_W = $clog2(MUL_LAT);

   logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

   // Counter arms as MULT enters EX, then holds the pipe until it drains.
   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if (load_id_ex && dec_is_mult) begin
         mul_cnt_d = CNT_W'(MUL_LAT - 1);
      end else if (mul_cnt_q != '0) begin
         mul_cnt_d = mul_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_cnt_q <= '0;
      end else begin
         mul_cnt_q <= mul_cnt_d;
      end
   end

   assign mul_busy = (mul_cnt_q != '0);
`else
   assign mul_busy = 1'b0;
`endif

   assign bus.ex_valid      = ex_ctrl_q.valid;
   assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
   assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
   assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
   assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
   assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
   assign bus.ex_func       = ex_func_q;
   assign bus.ex_dst        = ex_dst_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Directed-vector scoreboard bench for pipe_ctrl_hazard_unit; MULT cases follow
// whether MULDIV_EN is defined.
module tb_pipe_ctrl_hazard_unit;

   localparam logic [5:0] O_R   = 6'b000000;
   localparam logic [5:0] O_J   = 6'b000010;
   localparam logic [5:0] O_BEQ = 6'b000100;
   localparam logic [5:0] O_BNE = 6'b000101;
   localparam logic [5:0] O_LW  = 6'b100011;
   localparam logic [5:0] O_SW  = 6'b101011;
   localparam logic [5:0] O_BAD = 6'b111111;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_MUL = 6'b011000;

   // {pc_src[1:0], pc_write, ifid_write, ifid_flush, stall, illegal_op}
   localparam logic [6:0] C_ADV   = 7'b00_1_1_0_0_0;
   localparam logic [6:0] C_STALL = 7'b00_0_0_0_1_0;
   localparam logic [6:0] C_BR    = 7'b01_1_1_1_0_0;
   localparam logic [6:0] C_JMP   = 7'b10_1_1_1_0_0;
   localparam logic [6:0] C_ILL   = 7'b00_1_1_0_0_1;

   // {valid, mem_read, mem_write, alu_src, reg_write, mem_to_reg, func, dst}
   localparam logic [16:0] E_BUB  = 17'b0;
   localparam logic [16:0] E_CTL  = {6'b100000, 6'b000000, 5'd0};
   localparam logic [16:0] E_SW   = {6'b101100, F_ADD, 5'd0};
   localparam logic [16:0] E_MULT = {6'b100000, F_MUL, 5'd0};

   function automatic logic [16:0] e_lw(input logic [4:0] rt);
      return {6'b110111, F_ADD, rt};
   endfunction

   function automatic logic [16:0] e_r(input logic [5:0] fn, input logic [4:0] rd);
      return {6'b100010, fn, rd};
   endfunction

   logic clk;
   logic rst;

   pipe_ctrl_hazard_unit_if #(.REG_ADDR_W(5), .FUNC_W(6)) bus ();

   pipe_ctrl_hazard_unit #(
      .REG_ADDR_W (5),
      .FUNC_W     (6),
      .MUL_LAT    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   string       nm_q[$];
   logic [6:0]  comb_q[$];
   string       exnm_q[$];
   logic [16:0] ex_q[$];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic apply(input string nm, input logic r, input logic v,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic eq,
                        input logic [6:0] ec, input logic [16:0] ee);
      @(negedge clk);
      rst          = r;
      bus.id_valid = v;
      bus.opcode   = op;
      bus.func_in  = fn;
      bus.id_rs    = rs;
      bus.id_rt    = rt;
      bus.id_rd    = rd;
      bus.eq_regs  = eq;
      nm_q.push_back(nm);
      comb_q.push_back(ec);
      exnm_q.push_back(nm);
      ex_q.push_back(ee);
   endtask

   // Monitor: combinational outputs checked in the cycle the vector is applied,
   // the ID/EX bundle one edge later.
   initial begin : monitor
      string       nm;
      logic [6:0]  exp_c, act_c;
      logic [16:0] exp_e, act_e;
      forever begin
         @(negedge clk);
         #2;
         if (comb_q.size() > 0) begin
            nm    = nm_q.pop_front();
            exp_c = comb_q.pop_front();
            act_c = {bus.pc_src, bus.pc_write, bus.ifid_write, bus.ifid_flush,
                     bus.stall, bus.illegal_op};
            n_vec++;
            if (act_c !== exp_c) begin
               n_miss++;
               $display("FAIL %s comb: got %b required %b", nm, act_c, exp_c);
            end else begin
               $display("ok   %s comb=%b", nm, act_c);
            end
         end
         if (ex_q.size() > 1) begin
            nm    = exnm_q.pop_front();
            exp_e = ex_q.pop_front();
            act_e = {bus.ex_valid, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src,
                     bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_func, bus.ex_dst};
            n_vec++;
            if (act_e !== exp_e) begin
               n_miss++;
               $display("FAIL %s idex: got %b required %b", nm, act_e, exp_e);
            end else begin
               $display("ok   %s idex=%b", nm, act_e);
            end
         end
      end
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst          = 1'b1;
      bus.id_valid = 1'b0;
      bus.opcode   = '0;
      bus.func_in  = '0;
      bus.id_rs    = '0;
      bus.id_rt    = '0;
      bus.id_rd    = '0;
      bus.eq_regs  = 1'b0;

      //     name          rst  vld  op     fn     rs  rt  rd  eq   comb     idex
      apply("rst_idle",   1, 0, O_R,   '0,    0,  0,  0,  0, C_ADV,   E_BUB);
      apply("rst_lw",     1, 1, O_LW,  '0,    1,  2,  0,  0, C_ADV,   E_BUB);
      apply("lw_r2",      0, 1, O_LW,  '0,    1,  2,  0,  0, C_ADV,   e_lw(5'd2));
      apply("add_lduse",  0, 1, O_R,   F_ADD, 2,  6,  3,  0, C_STALL, E_BUB);
      apply("add_retry",  0, 1, O_R,   F_ADD, 2,  6,  3,  0, C_ADV,   e_r(F_ADD, 5'd3));
      apply("add_r4",     0, 1, O_R,   F_ADD, 1,  1,  4,  0, C_ADV,   e_r(F_ADD, 5'd4));
      apply("beq_haz",    0, 1, O_BEQ, '0,    4,  5,  0,  1, C_STALL, E_BUB);
      apply("beq_taken",  0, 1, O_BEQ, '0,    4,  5,  0,  1, C_BR,    E_CTL);
      apply("bne_ntaken", 0, 1, O_BNE, '0,    1,  1,  0,  1, C_ADV,   E_CTL);
      apply("jump",       0, 1, O_J,   '0,    0,  0,  0,  0, C_JMP,   E_CTL);
      apply("lw_r0",      0, 1, O_LW,  '0,    1,  0,  0,  0, C_ADV,   e_lw(5'd0));
      apply("add_rs_r0",  0, 1, O_R,   F_ADD, 0,  0,  7,  0, C_ADV,   e_r(F_ADD, 5'd7));
      apply("lw_r9",      0, 1, O_LW,  '0,    1,  9,  0,  0, C_ADV,   e_lw(5'd9));
      apply("sw_rt_haz",  0, 1, O_SW,  '0,    1,  9,  0,  0, C_STALL, E_BUB);
      apply("sw_retry",   0, 1, O_SW,  '0,    1,  9,  0,  0, C_ADV,   E_SW);
      apply("lw_r10",     0, 1, O_LW,  '0,    1, 10,  0,  0, C_ADV,   e_lw(5'd10));
      apply("lw_rt_nohz", 0, 1, O_LW,  '0,    3, 10,  0,  0, C_ADV,   e_lw(5'd10));
      apply("illegal",    0, 1, O_BAD, '0,    0,  0,  0,  0, C_ILL,   E_BUB);
      apply("novalid",    0, 0, O_BEQ, '0,    4,  4,  0,  1, C_ADV,   E_BUB);
`ifdef MULDIV_EN
      apply("mult",       0, 1, O_R,   F_MUL, 1,  2,  3,  0, C_ADV,   E_MULT);
      apply("mul_busy1",  0, 1, O_R,   F_ADD, 1,  2,  5,  0, C_STALL, E_BUB);
      apply("mul_busy2",  0, 1, O_R,   F_ADD, 1,  2,  5,  0, C_STALL, E_BUB);
      apply("mul_busy3",  0, 1, O_R,   F_ADD, 1,  2,  5,  0, C_STALL, E_BUB);
      apply("mul_done",   0, 1, O_R,   F_ADD, 1,  2,  5,  0, C_ADV,   e_r(F_ADD, 5'd5));
      apply("mult2",      0, 1, O_R,   F_MUL, 1,  2,  3,  0, C_ADV,   E_MULT);
      apply("mul2_busy",  0, 1, O_R,   F_ADD, 1,  2,  5,  0, C_STALL, E_BUB);
      apply("mul2_rst",   1, 1, O_R,   F_ADD, 1,  2,  5,  0, C_ADV,   E_BUB);
      apply("post_rst",   0, 1, O_R,   F_ADD, 1,  2,  5,  0, C_ADV,   e_r(F_ADD, 5'd5));
`else
      apply("mult_ill",   0, 1, O_R,   F_MUL, 1,  2,  3,  0, C_ILL,   E_BUB);
`endif
      apply("idle1",      0, 0, O_R,   '0,    0,  0,  0,  0, C_ADV,   E_BUB);
      apply("idle2",      0, 0, O_R,   '0,    0,  0,  0,  0, C_ADV,   E_BUB);

      @(negedge clk);
      #5;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
